nfa_symbol_feeder: RTL and testbench

Drives the STE array of the NFA engine by turning an incoming symbol stream into per-cycle `ste_run`, `ste_start_of_data`, `ste_reset` and per-STE `ste_match` vectors. A programmable symbol-to-match table holds one `NUM_STE`-bit row per symbol value; that row is the STE character class. The block sits between the engine's input stream buffer and the STE cluster.

---
 rtl/nfa_symbol_feeder.sv | 196 +++++++++++++++++++
 tb/tb_nfa_symbol_feeder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nfa_symbol_feeder.sv
// -----------------------------------------------------------------------------
// nfa_symbol_feeder
// Turns an incoming symbol stream into per-cycle STE drive signals
// (ste_run / ste_start_of_data / ste_reset / ste_match) for the NFA engine.
// A programmable table holds one NUM_STE-bit character-class row per symbol.
//
// Build option: define NFA_FEEDER_SYMBOL_COUNT_EN to implement the 32-bit
// symbol_count counter; when it is undefined symbol_count is tied to zero.
// -----------------------------------------------------------------------------
module nfa_symbol_feeder #(
    parameter int NUM_STE  = 64,
    parameter int SYMBOL_W = 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                cfg_we,
    input  logic [SYMBOL_W-1:0] cfg_addr,
    input  logic [NUM_STE-1:0]  cfg_data,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [SYMBOL_W-1:0] s_symbol,
    input  logic                s_last,
    output logic                ste_reset,
    output logic                ste_run,
    output logic                ste_start_of_data,
    output logic [NUM_STE-1:0]  ste_match,
    output logic                busy,
    output logic [31:0]         symbol_count
);

    localparam int NUM_ROWS = 1 << SYMBOL_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } state_e;

    state_e               state_q;
    state_e               state_d;

    // Set in CLEAR, dropped by the first accepted symbol of the stream.
    logic                 first_q;
    logic                 first_d;

    logic                 ste_reset_q;
    logic                 ste_reset_d;
    logic                 s_ready_q;
    logic                 s_ready_d;
    logic                 busy_q;
    logic                 busy_d;
    logic                 run_q;
    logic                 run_d;
    logic                 sod_q;
    logic                 sod_d;
    logic [NUM_STE-1:0]   match_q;
    logic [NUM_STE-1:0]   match_d;

    // Table write enable; only honoured while the feeder is idle.
    logic                 tbl_we_s;

    // Symbol-to-match table, one character-class row per symbol value.
    logic [NUM_STE-1:0]   table_q [NUM_ROWS];

    // Next-state logic and next values of all registered outputs.
    always_comb begin
        state_d  = state_q;
        first_d  = first_q;
        run_d    = 1'b0;
        sod_d    = 1'b0;
        match_d  = {NUM_STE{1'b0}};
        tbl_we_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The table write lands on the same edge that leaves IDLE,
                // and the table is not read before STREAM, so a write issued
                // together with a stream start is seen by that stream.
                tbl_we_s = cfg_we;
                if (s_valid) begin
                    state_d = ST_CLEAR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                state_d = ST_STREAM;
                first_d = 1'b1;
            end
            ST_STREAM: begin
                // s_ready is high throughout STREAM, so s_valid alone
                // qualifies an accept here.
                if (s_valid) begin
                    run_d   = 1'b1;
                    sod_d   = first_q;
                    first_d = 1'b0;
                    match_d = table_q[s_symbol];
                    if (s_last) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_STREAM;
                    end
                end else begin
                    state_d = ST_STREAM;
                end
            end
            ST_DRAIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs are registered versions of the next state, so they
        // line up exactly with the state they describe.
        ste_reset_d = (state_d == ST_CLEAR);
        s_ready_d   = (state_d == ST_STREAM);
        busy_d      = (state_d != ST_IDLE);
    end

    // State register and registered STE drive outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            first_q     <= 1'b0;
            ste_reset_q <= 1'b1;
            s_ready_q   <= 1'b0;
            busy_q      <= 1'b0;
            run_q       <= 1'b0;
            sod_q       <= 1'b0;
            match_q     <= {NUM_STE{1'b0}};
        end else begin
            state_q     <= state_d;
            first_q     <= first_d;
            ste_reset_q <= ste_reset_d;
            s_ready_q   <= s_ready_d;
            busy_q      <= busy_d;
            run_q       <= run_d;
            sod_q       <= sod_d;
            match_q     <= match_d;
        end
    end

    // Match table storage; every row is cleared by reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_ROWS; i++) begin
                table_q[i] <= {NUM_STE{1'b0}};
            end
        end else if (tbl_we_s) begin
            table_q[cfg_addr] <= cfg_data;
        end else begin
            table_q[cfg_addr] <= table_q[cfg_addr];
        end
    end

`ifdef NFA_FEEDER_SYMBOL_COUNT_EN
    logic [31:0] count_q;
    logic [31:0] count_d;

    // Symbol counter: cleared on entry to CLEAR, +1 per accepted symbol.
    always_comb begin
        count_d = count_q;
        if ((state_q == ST_IDLE) && (state_d == ST_CLEAR)) begin
            count_d = 32'd0;
        end else if ((state_q == ST_STREAM) && s_valid) begin
            count_d = count_q + 32'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Symbol counter register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= 32'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign symbol_count = count_q;
`else
    assign symbol_count = 32'd0;
`endif

    assign ste_reset         = ste_reset_q;
    assign s_ready           = s_ready_q;
    assign busy              = busy_q;
    assign ste_run           = run_q;
    assign ste_start_of_data = sod_q;
    assign ste_match         = match_q;

endmodule

// File: tb/tb_nfa_symbol_feeder.sv
// -----------------------------------------------------------------------------
// Testbench for nfa_symbol_feeder. Directed streams followed by randomized
// streams, checked against a stream-level reference model (table contents,
// per-stream symbol list and accept timing).
// -----------------------------------------------------------------------------
module tb_nfa_symbol_feeder;

    logic        clk;
    logic        rstn;
    logic        cfg_we;
    logic [7:0]  cfg_addr;
    logic [63:0] cfg_data;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_symbol;
    logic        s_last;
    logic        ste_reset;
    logic        ste_run;
    logic        ste_start_of_data;
    logic [63:0] ste_match;
    logic        busy;
    logic [31:0] symbol_count;

    int          n_tests;
    int          n_fail;

    // Reference model state
    logic [63:0] tbl_m [256];
    logic [31:0] cnt_m;

    nfa_symbol_feeder #(.NUM_STE(64), .SYMBOL_W(8)) dut (
        .clk               (clk),
        .rstn              (rstn),
        .cfg_we            (cfg_we),
        .cfg_addr          (cfg_addr),
        .cfg_data          (cfg_data),
        .s_valid           (s_valid),
        .s_ready           (s_ready),
        .s_symbol          (s_symbol),
        .s_last            (s_last),
        .ste_reset         (ste_reset),
        .ste_run           (ste_run),
        .ste_start_of_data (ste_start_of_data),
        .ste_match         (ste_match),
        .busy              (busy),
        .symbol_count      (symbol_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_count();
`ifdef NFA_FEEDER_SYMBOL_COUNT_EN
        return cnt_m;
`else
        return 32'd0;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 256; i++) tbl_m[i] = 64'd0;
        cnt_m = 32'd0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic er, input logic erdy,
                           input logic erun, input logic esod,
                           input logic [63:0] em, input logic ebusy);
        chk({tag, ".ste_reset"}, {63'd0, ste_reset}, {63'd0, er});
        chk({tag, ".s_ready"}, {63'd0, s_ready}, {63'd0, erdy});
        chk({tag, ".ste_run"}, {63'd0, ste_run}, {63'd0, erun});
        chk({tag, ".sod"}, {63'd0, ste_start_of_data}, {63'd0, esod});
        chk({tag, ".ste_match"}, ste_match, em);
        chk({tag, ".busy"}, {63'd0, busy}, {63'd0, ebusy});
        chk({tag, ".symbol_count"}, {32'd0, symbol_count}, {32'd0, exp_count()});
    endtask

    // Table write issued while the feeder is idle.
    task automatic cfg_write(input logic [7:0] a, input logic [63:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        step();
        cfg_we   = 1'b0;
        tbl_m[a] = d;
        chk_out("cfgwr", 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
    endtask

    // Drive one stream. gaps[i] = idle cycles before symbol i (i > 0).
    // wr: table write issued in the same cycle the stream starts.
    // busy_wr: attempt a table write during STREAM (must be ignored).
    // abort_at: assert reset after this many accepts (-1 = never).
    task automatic run_stream(input logic [7:0] syms[$], input int gaps[$],
                              input bit wr, input logic [7:0] wa, input logic [63:0] wd,
                              input bit busy_wr, input int abort_at);
        int n;
        int idx;
        int gapleft;
        bit acc;
        logic [7:0] sym;
        n = syms.size();
        s_valid  = 1'b1;
        s_symbol = syms[0];
        s_last   = (n == 1);
        if (wr) begin
            cfg_we = 1'b1; cfg_addr = wa; cfg_data = wd;
        end
        step();
        cfg_we = 1'b0;
        if (wr) tbl_m[wa] = wd;
        cnt_m = 32'd0;
        chk_out("clear", 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1);
        step();
        chk_out("stream_entry", 1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b1);
        idx = 0;
        gapleft = 0;
        while (idx < n) begin
            if (busy_wr && idx == 1 && gapleft == 0) begin
                cfg_we = 1'b1; cfg_addr = 8'h41; cfg_data = {64{1'b1}};
            end
            if (gapleft > 0) begin
                s_valid = 1'b0;
                gapleft--;
                acc = 1'b0;
            end else begin
                s_valid  = 1'b1;
                s_symbol = syms[idx];
                s_last   = (idx == n - 1);
                acc      = 1'b1;
            end
            sym = s_symbol;
            step();
            cfg_we = 1'b0;
            if (acc) begin
                cnt_m = cnt_m + 32'd1;
                chk_out("apply", 1'b0, (idx != n - 1), 1'b1, (idx == 0), tbl_m[sym], 1'b1);
                idx++;
                if (idx < n) gapleft = gaps[idx];
                if (idx == abort_at) begin
                    rstn    = 1'b0;
                    s_valid = 1'b0;
                    s_last  = 1'b0;
                    #1;
                    model_reset();
                    chk_out("async_rst", 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
                    step();
                    rstn = 1'b1;
                    step();
                    chk_out("post_rst", 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
                    return;
                end
            end else begin
                chk_out("bubble", 1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 1'b1);
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        step();
        chk_out("idle_back", 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
        step();
        chk_out("idle_hold", 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
    endtask

    initial begin
        logic [7:0] sq[$];
        int         gq[$];
        int         len;
        n_tests  = 0;
        n_fail   = 0;
        rstn     = 1'b0;
        cfg_we   = 1'b0;
        cfg_addr = 8'd0;
        cfg_data = 64'd0;
        s_valid  = 1'b0;
        s_symbol = 8'd0;
        s_last   = 1'b0;
        model_reset();

        // Reset held for 3 cycles
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("in_reset", 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
        end
        rstn = 1'b1;
        #1;
        chk_out("released", 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
        step();
        chk_out("after_rel", 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);

        // Config then "ABA" at full rate
        cfg_write(8'h41, 64'h1);
        cfg_write(8'h42, 64'h2);
        sq = {8'h41, 8'h42, 8'h41};
        gq = {0, 0, 0};
        run_stream(sq, gq, 1'b0, 8'h00, 64'd0, 1'b0, -1);

        // Bubbles of 2 cycles between symbols 2 and 3
        sq = {8'h42, 8'h41, 8'h42, 8'h41};
        gq = {0, 0, 2, 0};
        run_stream(sq, gq, 1'b0, 8'h00, 64'd0, 1'b0, -1);

        // Config attempt during STREAM is ignored
        sq = {8'h42, 8'h43, 8'h41};
        gq = {0, 0, 0};
        run_stream(sq, gq, 1'b0, 8'h00, 64'd0, 1'b1, -1);

        // Single-symbol stream; "A" must still map to 0x1
        sq = {8'h41};
        gq = {0};
        run_stream(sq, gq, 1'b0, 8'h00, 64'd0, 1'b0, -1);

        // Write and stream start in the same idle cycle
        sq = {8'h44, 8'h41};
        gq = {0, 1};
        run_stream(sq, gq, 1'b1, 8'h44, 64'hDEAD_BEEF_0123_4567, 1'b0, -1);

        // Reset after 2 of 5 symbols, then a fresh stream
        sq = {8'h41, 8'h42, 8'h41, 8'h42, 8'h41};
        gq = {0, 0, 0, 0, 0};
        run_stream(sq, gq, 1'b0, 8'h00, 64'd0, 1'b0, 2);
        sq = {8'h41, 8'h42};
        gq = {0, 0};
        run_stream(sq, gq, 1'b1, 8'h41, 64'h5, 1'b0, -1);

        // Randomized streams
        for (int t = 0; t < 25; t++) begin
            if ($urandom_range(1, 0) == 1) begin
                cfg_write(8'h40 + 8'($urandom_range(7, 0)), {$urandom(), $urandom()});
            end
            len = $urandom_range(8, 1);
            sq.delete();
            gq.delete();
            for (int k = 0; k < len; k++) begin
                sq.push_back(8'h40 + 8'($urandom_range(9, 0)));
                gq.push_back($urandom_range(2, 0) == 2 ? $urandom_range(3, 1) : 0);
            end
            run_stream(sq, gq, ($urandom_range(3, 0) == 0), 8'h40 + 8'($urandom_range(7, 0)),
                       {$urandom(), $urandom()}, ($urandom_range(1, 0) == 1),
                       ($urandom_range(7, 0) == 0) ? $urandom_range(len, 1) : -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
